wb_lsu_master: RTL and testbench
================================

WB_LSU_MASTER -- requirements
Module: wb_lsu_master

Interface
REQ-001 Parameter: TIMEOUT, default 16, bus-cycle abort threshold in clocks while ACK is absent.
REQ-002 Port: clk  in  1  sole clock; all state changes on rising edge.
REQ-003 Port: rstn  in  1  reset, asynchronous, active-low.
REQ-004 Port: req_valid  in  1 / req_ready  out  1  core request handshake.
REQ-005 Port: req_we  in  1 / req_addr  in  32 / req_wdata  in  32 / req_funct3  in  3  (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-006 Port: rsp_valid  out  1 / rsp_rdata  out  32 / rsp_err  out  1  one-cycle response pulse.
REQ-007 Port: wb_cyc, wb_stb, wb_we  out  1 / wb_adr  out  32 / wb_dat_o  out  32 / wb_sel  out  4  Wishbone B4 classic master outputs.
REQ-008 Port: wb_dat_i  in  32 / wb_ack  in  1  slave read data and acknowledge.

Function
REQ-009 States IDLE, BUS, RESP; req_ready=1 only in IDLE.
REQ-010 IDLE: req_valid=1 latches addr/wdata/we/funct3; misaligned (H with addr[0]=1, W with addr[1:0]!=0) or funct3 in {011,110,111} -> RESP with err, no bus cycle; else -> BUS.
REQ-011 BUS: wb_cyc=wb_stb=1 (registered), wb_adr={addr[31:2],2'b00}, wb_we=latched we.
REQ-012 wb_sel: B 0001<<addr[1:0]; H 0011<<{addr[1],0}; W 1111.
REQ-013 wb_dat_o: B byte replicated x4; H half replicated x2; W as-is; driven for reads too (don't-care).
REQ-014 BUS, wb_ack=1: capture wb_dat_i, cyc/stb low on next cycle, -> RESP; master never holds STB past the ACK cycle (slave ACK held while STB held must not yield a second transfer).
REQ-015 Load data: selected lane shifted to bit 0; B/H sign-extended, BU/HU zero-extended; stores return rsp_rdata=0.
REQ-016 RESP: rsp_valid=1 exactly one cycle, rsp_err per REQ-010/REQ-021, -> IDLE.
REQ-017 Latency with 1-cycle-ACK slave: accept at edge N, STB visible N..N+1, ACK sampled N+2, rsp_valid N+3 cycle; back-to-back request accepted in IDLE the cycle after RESP.
REQ-018 wb_ack outside BUS ignored; no state change.
REQ-019 rsp_rdata, rsp_err hold last values outside RESP.

Reset
REQ-020 rstn=0 asynchronously: state=IDLE, wb_cyc=wb_stb=wb_we=0, wb_adr=0, wb_dat_o=0, wb_sel=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0; reset mid-BUS drops CYC immediately, no response issued.

Configuration
REQ-021 Macro WB_LSU_TIMEOUT_EN defined: counter cleared on BUS entry, increments each BUS cycle without ACK; at TIMEOUT cycles drop cyc/stb, -> RESP with rsp_err=1, rsp_rdata=0; ACK on the same cycle as expiry wins (normal completion).
REQ-022 Macro undefined: no counter; BUS waits indefinitely for ACK; TIMEOUT unused.

Verification
REQ-023 LW addr 0x100, slave returns 0xDEADBEEF with 1-cycle ACK -> wb_sel=1111, rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 3 cycles after accept.
REQ-024 LB addr 0x103, wb_dat_i=0x80112233 -> wb_sel=1000, rsp_rdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-025 SH addr 0x102, wdata 0x0000ABCD -> wb_we=1, wb_sel=1100, wb_dat_o=0xABCDABCD, single ACK, rsp_valid one cycle.
REQ-026 LW addr 0x101 -> no wb_cyc assertion, rsp_err=1 next cycle after accept.
REQ-027 WB_LSU_TIMEOUT_EN, TIMEOUT=16, slave never ACKs -> cyc drops after 16 BUS cycles, rsp_err=1; without macro cyc stays high.
REQ-028 rstn low during BUS -> wb_cyc=0 same cycle, no rsp_valid; next request after release completes normally.

Source files
------------

// File: rtl/wb_lsu_master.sv
// rtl/wb_lsu_master.sv - load/store unit to Wishbone B4 classic master bridge
// Optional bus-cycle timeout abort enabled by defining WB_LSU_TIMEOUT_EN.
module wb_lsu_master #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [31:0] wb_adr,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t      state, state_nx;
    logic [1:0]  addr_lo;
    logic [2:0]  f3_q;
    logic        we_q;
    logic        accept, reject, expire;
    logic [3:0]  sel_d;
    logic [31:0] dat_d, shifted, load_data;

    // Request decode: illegal width codes and misalignment never reach the bus
    always_comb begin
        reject = 1'b0;
        sel_d  = 4'b1111;
        dat_d  = req_wdata;
        if (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11)
            reject = 1'b1;
        if (req_funct3[1:0] == 2'b01 && req_addr[0])
            reject = 1'b1;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
            reject = 1'b1;
        case (req_funct3[1:0])
            2'b00: begin
                sel_d = 4'b0001 << req_addr[1:0];
                dat_d = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                sel_d = 4'b0011 << {req_addr[1], 1'b0};
                dat_d = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted   = wb_dat_i >> {addr_lo, 3'b000};
        load_data = shifted;
        case (f3_q)
            3'b000: load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001: load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100: load_data = {24'h0, shifted[7:0]};
            3'b101: load_data = {16'h0, shifted[15:0]};
            default: ;
        endcase
        if (we_q)
            load_data = 32'h0;
    end

`ifdef WB_LSU_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] to_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            to_cnt <= '0;
        else if (accept)
            to_cnt <= '0;
        else if (state == BUS && !wb_ack)
            to_cnt <= to_cnt + 1'b1;
    end

    assign expire = (state == BUS) && !wb_ack && (to_cnt == CW'(TIMEOUT - 1));
`else
    localparam int unused_timeout = TIMEOUT;
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                accept   = 1'b1;
                state_nx = reject ? RESP : BUS;
            end
            BUS:  if (wb_ack || expire) state_nx = RESP;
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_lo   <= 2'b00;
            f3_q      <= 3'b000;
            we_q      <= 1'b0;
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
            wb_we     <= 1'b0;
            wb_adr    <= 32'h0;
            wb_dat_o  <= 32'h0;
            wb_sel    <= 4'h0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    addr_lo <= req_addr[1:0];
                    f3_q    <= req_funct3;
                    we_q    <= req_we;
                    if (reject) begin
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 32'h0;
                    end else begin
                        wb_cyc   <= 1'b1;
                        wb_stb   <= 1'b1;
                        wb_we    <= req_we;
                        wb_adr   <= {req_addr[31:2], 2'b00};
                        wb_sel   <= sel_d;
                        wb_dat_o <= dat_d;
                    end
                end
                // STB drops right after the ACK cycle so a held ACK cannot retrigger
                BUS: if (wb_ack) begin
                    wb_cyc    <= 1'b0;
                    wb_stb    <= 1'b0;
                    rsp_rdata <= load_data;
                    rsp_err   <= 1'b0;
                end else if (expire) begin
                    wb_cyc    <= 1'b0;
                    wb_stb    <= 1'b0;
                    rsp_rdata <= 32'h0;
                    rsp_err   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_lsu_master.sv
// tb/tb_wb_lsu_master.sv - self-checking bench for wb_lsu_master
// Timeout checks follow the WB_LSU_TIMEOUT_EN define used for the DUT build.
module tb_wb_lsu_master;

    logic        clk, rstn;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        wb_cyc, wb_stb, wb_we, wb_ack;
    logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel;

    wb_lsu_master #(.TIMEOUT(16)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_dat_o(wb_dat_o), .wb_sel(wb_sel), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // slave modes: 0 one-cycle ack, 1 ack held while STB, 2 never, 3 random delay
    int          mode = 0;
    logic        ack_r, ack_force;
    logic [31:0] slave_rd;
    assign wb_ack   = ack_r | ack_force;
    assign wb_dat_i = slave_rd;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) ack_r <= 1'b0;
        else case (mode)
            0: ack_r <= wb_stb & ~ack_r;
            1: ack_r <= wb_stb;
            3: ack_r <= wb_stb & ~ack_r & ($urandom_range(0, 2) == 0);
            default: ack_r <= 1'b0;
        endcase
    end

    int          cyc_cnt = 0, xfer_cnt = 0, rsp_cnt = 0, cyc_hi = 0;
    logic [3:0]  xfer_sel;
    logic [31:0] xfer_dat, xfer_adr;
    logic        xfer_we;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (wb_cyc && wb_stb && wb_ack) begin
            xfer_cnt <= xfer_cnt + 1;
            xfer_sel <= wb_sel;
            xfer_dat <= wb_dat_o;
            xfer_adr <= wb_adr;
            xfer_we  <= wb_we;
        end
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
        if (wb_cyc) cyc_hi <= cyc_hi + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: access size in bytes, lane offset, replication and extension by arithmetic
    function automatic void model(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                                  input logic [31:0] wd, input logic [31:0] rd,
                                  output logic err, output logic [31:0] rdata,
                                  output logic [3:0] sel, output logic [31:0] dat);
        int size, off;
        longint val, mask;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        err = (size == 0) || ((addr % size) != 0);
        off = int'(addr % 4);
        sel = (size == 0) ? 4'h0 : 4'(((1 << size) - 1) << off);
        dat = 32'h0;
        for (int i = 0; i < 4; i++)
            if (size != 0) dat[8*i +: 8] = wd[8*(i % size) +: 8];
        mask = (longint'(1) << (8 * size)) - 1;
        val  = (longint'(rd) >> (8 * off)) & mask;
        if ((f3 == 3'd0 || f3 == 3'd1) && size != 0 && val[8*size-1])
            val = val | ~mask;
        rdata = we ? 32'h0 : val[31:0];
    endfunction

    logic        obs_err;
    logic [31:0] obs_rdata;
    int          obs_lat, obs_xfer;

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wd);
        int  n, acc, x0;
        bit  got;
        logic [31:0] held;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wd;
        acc = cyc_cnt; x0 = xfer_cnt;
        @(negedge clk);
        req_valid = 1'b0;
        got = 0;
        for (n = 0; n < 80 && !got; n++) begin
            if (rsp_valid) begin
                got = 1; obs_lat = cyc_cnt - acc; obs_err = rsp_err; obs_rdata = rsp_rdata;
            end else @(negedge clk);
        end
        chk("rsp_seen", 32'(got), 32'd1);
        obs_xfer = xfer_cnt - x0;
        held = rsp_rdata;
        @(negedge clk);
        chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        chk("rdata_hold", rsp_rdata, held);
        chk("ready_after_resp", 32'(req_ready), 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        logic [31:0] rdata;
        logic [3:0]  sel;
        logic [31:0] dat;
    } vec_t;

    vec_t vt[11];

    initial begin
        logic        e_err;
        logic [31:0] e_rd, e_dat;
        logic [3:0]  e_sel;
        int          r0, h0;

        vt[0]  = '{1'b0, 32'h100, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 4'hF, 32'h0};
        vt[1]  = '{1'b0, 32'h103, 3'b000, 32'h0,        32'h80112233, 1'b0, 32'hFFFFFF80, 4'h8, 32'h0};
        vt[2]  = '{1'b0, 32'h103, 3'b100, 32'h0,        32'h80112233, 1'b0, 32'h00000080, 4'h8, 32'h0};
        vt[3]  = '{1'b1, 32'h102, 3'b001, 32'h0000ABCD, 32'h0,        1'b0, 32'h0,        4'hC, 32'hABCDABCD};
        vt[4]  = '{1'b0, 32'h101, 3'b010, 32'h0,        32'h0,        1'b1, 32'h0,        4'h0, 32'h0};
        vt[5]  = '{1'b0, 32'h102, 3'b001, 32'h0,        32'h80112233, 1'b0, 32'hFFFF8011, 4'hC, 32'h0};
        vt[6]  = '{1'b0, 32'h100, 3'b101, 32'h0,        32'h80112233, 1'b0, 32'h00002233, 4'h3, 32'h0};
        vt[7]  = '{1'b1, 32'h101, 3'b000, 32'h12345678, 32'h0,        1'b0, 32'h0,        4'h2, 32'h78787878};
        vt[8]  = '{1'b0, 32'h200, 3'b011, 32'h0,        32'h0,        1'b1, 32'h0,        4'h0, 32'h0};
        vt[9]  = '{1'b0, 32'h103, 3'b001, 32'h0,        32'h0,        1'b1, 32'h0,        4'h0, 32'h0};
        vt[10] = '{1'b1, 32'h104, 3'b010, 32'hCAFEF00D, 32'h0,        1'b0, 32'h0,        4'hF, 32'hCAFEF00D};

        rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_funct3 = '0; ack_force = 1'b0; slave_rd = '0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", 32'(wb_cyc), 0);
        chk("rst_stb", 32'(wb_stb), 0);
        chk("rst_we", 32'(wb_we), 0);
        chk("rst_adr", wb_adr, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_sel", 32'(wb_sel), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", 32'(rsp_err), 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 1);

        mode = 0;
        for (int i = 0; i < 11; i++) begin
            slave_rd = vt[i].rd;
            do_req(vt[i].we, vt[i].addr, vt[i].f3, vt[i].wd);
            chk($sformatf("v%0d_err", i), 32'(obs_err), 32'(vt[i].err));
            if (vt[i].err) begin
                chk($sformatf("v%0d_xfers", i), obs_xfer, 0);
                chk($sformatf("v%0d_lat", i), obs_lat, 1);
            end else begin
                chk($sformatf("v%0d_xfers", i), obs_xfer, 1);
                chk($sformatf("v%0d_lat", i), obs_lat, 3);
                chk($sformatf("v%0d_rdata", i), obs_rdata, vt[i].rdata);
                chk($sformatf("v%0d_sel", i), 32'(xfer_sel), 32'(vt[i].sel));
                chk($sformatf("v%0d_we", i), 32'(xfer_we), 32'(vt[i].we));
                chk($sformatf("v%0d_adr", i), xfer_adr, {vt[i].addr[31:2], 2'b00});
                if (vt[i].we) chk($sformatf("v%0d_dat", i), xfer_dat, vt[i].dat);
            end
        end

        for (int i = 0; i < 40; i++) begin
            logic        we;
            logic [31:0] addr, wd;
            logic [2:0]  f3;
            mode = ($urandom_range(0, 1) == 0) ? 0 : 3;
            we   = 1'($urandom_range(0, 1));
            addr = $urandom;
            wd   = $urandom;
            slave_rd = $urandom;
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 2) == 0 ? 3 : $urandom_range(6, 7));
            else if (we) f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            model(we, addr, f3, wd, slave_rd, e_err, e_rd, e_sel, e_dat);
            do_req(we, addr, f3, wd);
            chk("rnd_err", 32'(obs_err), 32'(e_err));
            chk("rnd_xfers", obs_xfer, e_err ? 0 : 1);
            if (!e_err) begin
                chk("rnd_rdata", obs_rdata, e_rd);
                chk("rnd_sel", 32'(xfer_sel), 32'(e_sel));
                chk("rnd_adr", xfer_adr, {addr[31:2], 2'b00});
                if (we) chk("rnd_dat", xfer_dat, e_dat);
            end
        end

        mode = 1;
        slave_rd = 32'h55AA1234;
        do_req(1'b0, 32'h10, 3'b010, 32'h0);
        chk("held_ack_xfers", obs_xfer, 1);
        chk("held_ack_rdata", obs_rdata, 32'h55AA1234);

        mode = 0;
        repeat (2) @(negedge clk);
        r0 = rsp_cnt;
        ack_force = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stray_ack_cyc", 32'(wb_cyc), 0);
            chk("stray_ack_ready", 32'(req_ready), 1);
        end
        ack_force = 1'b0;
        @(negedge clk);
        chk("stray_ack_rsp", rsp_cnt - r0, 0);

        mode = 2;
        r0 = rsp_cnt;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; req_funct3 = 3'b010;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("hang_cyc_high", 32'(wb_cyc), 1);
`ifndef WB_LSU_TIMEOUT_EN
        repeat (35) @(negedge clk);
        chk("no_timeout_cyc_high", 32'(wb_cyc), 1);
        chk("no_timeout_rsp", rsp_cnt - r0, 0);
`endif
        rstn = 1'b0;
        #1;
        chk("midbus_rst_cyc", 32'(wb_cyc), 0);
        chk("midbus_rst_stb", 32'(wb_stb), 0);
        repeat (2) @(negedge clk);
        chk("midbus_rst_rsp", rsp_cnt - r0, 0);
        rstn = 1'b1;

`ifdef WB_LSU_TIMEOUT_EN
        h0 = cyc_hi;
        do_req(1'b0, 32'h80, 3'b010, 32'h0);
        chk("timeout_err", 32'(obs_err), 1);
        chk("timeout_rdata", obs_rdata, 0);
        chk("timeout_cyc_cycles", cyc_hi - h0, 16);
`else
        h0 = 0;
`endif

        mode = 0;
        slave_rd = 32'h0BADF00D;
        do_req(1'b0, 32'h300, 3'b010, 32'h0);
        chk("post_rst_err", 32'(obs_err), 0);
        chk("post_rst_rdata", obs_rdata, 32'h0BADF00D);
        chk("post_rst_lat", obs_lat, 3 + h0 * 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
